// File: rtl/bram_sdp_pipe_pkg.sv
// Shared types and constants for the bram_sdp_pipe block.
// Optional feature macro: BRAM_SDP_PIPE_OUTREG_EN (extra output register, read latency 2).
package bram_sdp_pipe_pkg;

    // Controller states: CLEAR zero-fills the array after reset, READY serves requests.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Cycles from an accepted rd_en to its rd_valid pulse.
`ifdef BRAM_SDP_PIPE_OUTREG_EN
    localparam int RD_LATENCY = 2;
`else
    localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/bram_sdp_core.sv
// Simple dual-port storage array: one byte-enabled write port and one
// registered read port, both on clk. A read to the address being written
// in the same cycle returns the old word; the wrapper merges new bytes.
module bram_sdp_core #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      i_wr_en,
    input  logic [ADDR_WIDTH-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic [DATA_WIDTH/8-1:0]   i_wr_be,
    input  logic                      i_rd_en,
    input  logic [ADDR_WIDTH-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0]     o_rd_data
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Byte-masked write and registered read of the storage array.
    // NOTE: the array has no reset branch so it maps onto block RAM; its
    // contents become defined only through the wrapper's clear sequence.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bram_sdp_pipe.sv
// Byte-enabled simple dual-port RAM with a post-reset zero-fill sequence,
// write-first collision handling and a fixed-latency read pipeline.
// Optional feature macro: BRAM_SDP_PIPE_OUTREG_EN adds an output register
// stage (read latency 2 instead of 1).
module bram_sdp_pipe
    import bram_sdp_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic                      rd_valid,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      init_done
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_cnt;

    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_waddr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;
    logic [NUM_BYTES-1:0]    w_mem_wbe;
    logic                    w_rd_accept;
    logic                    w_collision;
    logic [DATA_WIDTH-1:0]   w_core_rdata;
    logic [DATA_WIDTH-1:0]   w_merged;

    logic                    r_rd_v1;
    logic                    r_coll;
    logic [DATA_WIDTH-1:0]   r_coll_data;
    logic [NUM_BYTES-1:0]    r_coll_be;

    // State register and clear-address counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == CLEAR) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Next-state logic and the write/read port mux between clear and user traffic.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        w_mem_waddr  = wr_addr;
        w_mem_wdata  = wr_data;
        w_mem_wbe    = wr_be;
        w_rd_accept  = 1'b0;
        case (r_state)
            CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_waddr = r_cnt;
                w_mem_wdata = '0;
                w_mem_wbe   = '1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_next = READY;
                end
            end
            READY: begin
                w_mem_we    = wr_en;
                w_rd_accept = rd_en;
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    // A read hitting the address written in the same cycle must see the new bytes.
    assign w_collision = w_rd_accept && wr_en && (wr_addr == rd_addr);

    bram_sdp_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk        (clk),
        .i_wr_en    (w_mem_we),
        .i_wr_addr  (w_mem_waddr),
        .i_wr_data  (w_mem_wdata),
        .i_wr_be    (w_mem_wbe),
        .i_rd_en    (w_rd_accept),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (w_core_rdata)
    );

    // First read stage: valid flag and collision flag travel alongside the array read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_v1 <= 1'b0;
            r_coll  <= 1'b0;
        end else begin
            r_rd_v1 <= w_rd_accept;
            r_coll  <= w_collision;
        end
    end

    // Capture the colliding write's bytes for the merge one cycle later.
    always_ff @(posedge clk) begin
        if (w_collision) begin
            r_coll_data <= wr_data;
            r_coll_be   <= wr_be;
        end
    end

    // Write-first merge: enabled collision bytes replace the old word's bytes.
    always_comb begin
        w_merged = w_core_rdata;
        if (r_coll) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (r_coll_be[b]) begin
                    w_merged[8*b +: 8] = r_coll_data[8*b +: 8];
                end
            end
        end
    end

`ifdef BRAM_SDP_PIPE_OUTREG_EN
    logic                    r_rd_v2;
    logic [DATA_WIDTH-1:0]   r_rd_data;

    // Output register stage: data loads only on a completed read, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_v2   <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_v2 <= r_rd_v1;
            if (r_rd_v1) begin
                r_rd_data <= w_merged;
            end
        end
    end

    assign rd_valid = r_rd_v2;
    assign rd_data  = r_rd_data;
`else
    logic [DATA_WIDTH-1:0]   r_rd_hold;

    // Remember the last delivered word so rd_data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_hold <= '0;
        end else if (r_rd_v1) begin
            r_rd_hold <= w_merged;
        end
    end

    assign rd_valid = r_rd_v1;
    assign rd_data  = r_rd_v1 ? w_merged : r_rd_hold;
`endif

    assign init_done = (r_state == READY);

endmodule
